cordic_nco_rotator: RTL and testbench

Parametrised, fully pipelined CORDIC engine with an integrated phase accumulator. It is the next generation of the single-mode `Cordic` I/Q rotator. It adds a per-sample valid qualifier, a loadable accumulator, configurable widths and depth, and a per-sample vectoring mode that returns magnitude and angle. It sits between the sample source and the mixer/demodulator back end, one sample per clock.

---
 rtl/cordic_nco_rotator_pkg.sv | 53 +++++
 rtl/cordic_nco_rotator_if.sv | 29 ++
 rtl/cordic_nco_rotator_stage.sv | 66 ++++++
 rtl/cordic_nco_rotator.sv | 119 +++++++++++
 tb/tb_cordic_nco_rotator.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_nco_rotator_pkg.sv
// Shared CORDIC constants: arctangent table, gain, quadrant offsets and mode encoding.
package cordic_pkg;

   typedef enum logic {ROTATE = 1'b0, VECTOR = 1'b1} mode_e;

   // K = 1.64676 as unsigned fixed point with 15 fraction bits
   localparam logic [15:0] CORDIC_GAIN = 16'hD2C9;

   localparam logic [31:0] QTR32  = 32'h4000_0000;
   localparam logic [31:0] HALF32 = 32'h8000_0000;
   localparam logic [31:0] TQTR32 = 32'hC000_0000;

   // round(atan(2^-i) / 2pi * 2^32), rescaled to a narrower phase word by right shift
   function automatic logic [31:0] atan_tab(input int i, input int pw);
      logic [31:0] t;
      case (i)
         0:  t = 32'h2000_0000;
         1:  t = 32'h12E4_051E;
         2:  t = 32'h09FB_385B;
         3:  t = 32'h0511_11D4;
         4:  t = 32'h028B_0D43;
         5:  t = 32'h0145_D7E1;
         6:  t = 32'h00A2_F61E;
         7:  t = 32'h0051_7C55;
         8:  t = 32'h0028_BE53;
         9:  t = 32'h0014_5F2F;
         10: t = 32'h000A_2F98;
         11: t = 32'h0005_17CC;
         12: t = 32'h0002_8BE6;
         13: t = 32'h0001_45F3;
         14: t = 32'h0000_A2FA;
         15: t = 32'h0000_517D;
         16: t = 32'h0000_28BE;
         17: t = 32'h0000_145F;
         18: t = 32'h0000_0A30;
         19: t = 32'h0000_0518;
         20: t = 32'h0000_028C;
         21: t = 32'h0000_0146;
         22: t = 32'h0000_00A3;
         23: t = 32'h0000_0051;
         24: t = 32'h0000_0029;
         25: t = 32'h0000_0014;
         26: t = 32'h0000_000A;
         27: t = 32'h0000_0005;
         28: t = 32'h0000_0003;
         29: t = 32'h0000_0001;
         30: t = 32'h0000_0001;
         default: t = 32'h0000_0000;
      endcase
      return t >> (32 - pw);
   endfunction

endpackage

// File: rtl/cordic_nco_rotator_if.sv
// Sample-in / result-out bundle of the CORDIC NCO rotator; slave is the engine side.
interface cordic_nco_rotator_if #(
   parameter int IN_W    = 16,
   parameter int OUT_W   = 22,
   parameter int PHASE_W = 32
);
   logic                      in_valid;
   logic                      mode;
   logic signed [IN_W-1:0]    xin;
   logic signed [IN_W-1:0]    yin;
   logic        [PHASE_W-1:0] phase_step;
   logic                      phase_load;
   logic        [PHASE_W-1:0] phase_init;
   logic                      out_valid;
   logic                      out_mode;
   logic signed [OUT_W-1:0]   xout;
   logic signed [OUT_W-1:0]   yout;
   logic        [PHASE_W-1:0] phase_out;

   modport master (
      output in_valid, mode, xin, yin, phase_step, phase_load, phase_init,
      input  out_valid, out_mode, xout, yout, phase_out
   );

   modport slave (
      input  in_valid, mode, xin, yin, phase_step, phase_load, phase_init,
      output out_valid, out_mode, xout, yout, phase_out
   );
endinterface

// File: rtl/cordic_nco_rotator_stage.sv
// One registered CORDIC micro-rotation by atan(2^-SHIFT); one clock, no stall.
module cordic_stage
   import cordic_pkg::*;
#(
   parameter int W     = 22,
   parameter int PW    = 32,
   parameter int SHIFT = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                vld_i,
   input  mode_e               mode_i,
   input  logic signed [W-1:0] x_i,
   input  logic signed [W-1:0] y_i,
   input  logic [PW-1:0]       z_i,
   output logic                vld_o,
   output mode_e               mode_o,
   output logic signed [W-1:0] x_o,
   output logic signed [W-1:0] y_o,
   output logic [PW-1:0]       z_o
);
   localparam logic [PW-1:0] ATAN = PW'(atan_tab(SHIFT, PW));

   logic                vld_q;
   mode_e               mode_q;
   logic signed [W-1:0] x_q, y_q, x_d, y_d, xs, ys;
   logic [PW-1:0]       z_q, z_d;
   logic                cw;

   always_comb begin
      // cw means d = -1: vectoring drives y toward zero (y = 0 counts as positive)
      cw  = (mode_i == VECTOR) ? !y_i[W-1] : z_i[PW-1];
      xs  = x_i >>> SHIFT;
      ys  = y_i >>> SHIFT;
      x_d = x_i - ys;
      y_d = y_i + xs;
      z_d = z_i - ATAN;
      if (cw) begin
         x_d = x_i + ys;
         y_d = y_i - xs;
         z_d = z_i + ATAN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         mode_q <= ROTATE;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
      end else begin
         vld_q  <= vld_i;
         mode_q <= mode_i;
         x_q    <= x_d;
         y_q    <= y_d;
         z_q    <= z_d;
      end
   end

   assign vld_o  = vld_q;
   assign mode_o = mode_q;
   assign x_o    = x_q;
   assign y_o    = y_q;
   assign z_o    = z_q;
endmodule

// File: rtl/cordic_nco_rotator.sv
// Phase-accumulating CORDIC rotate/vector engine, one sample per clock.
// Latency STAGES+1 clocks; no backpressure, valid and mode travel with the data.
module cordic_nco_rotator
   import cordic_pkg::*;
#(
   parameter int IN_W    = 16,
   parameter int OUT_W   = 22,
   parameter int PHASE_W = 32,
   parameter int STAGES  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   cordic_nco_rotator_if.slave io
);
   localparam logic [PHASE_W-1:0] QTR  = PHASE_W'(QTR32  >> (32 - PHASE_W));
   localparam logic [PHASE_W-1:0] HALF = PHASE_W'(HALF32 >> (32 - PHASE_W));
   localparam logic [PHASE_W-1:0] TQTR = PHASE_W'(TQTR32 >> (32 - PHASE_W));

   logic [PHASE_W-1:0]      acc_q, acc_d, p;
   mode_e                   mode_in;
   logic signed [OUT_W-1:0] xe, ye;
   logic                    pv_q;
   mode_e                   pm_q;
   logic signed [OUT_W-1:0] px_q, py_q, px_d, py_d;
   logic [PHASE_W-1:0]      pz_q, pz_d;

   assign mode_in = mode_e'(io.mode);
   assign p       = io.phase_load ? io.phase_init : acc_q;
   assign xe      = {{(OUT_W-IN_W){io.xin[IN_W-1]}}, io.xin};
   assign ye      = {{(OUT_W-IN_W){io.yin[IN_W-1]}}, io.yin};

   // Bubbles leave the phase untouched so the tone stays coherent across gaps
   always_comb begin
      acc_d = acc_q;
      if (io.in_valid)
         acc_d = p + io.phase_step;
      else if (io.phase_load)
         acc_d = io.phase_init;
   end

   always_comb begin
      px_d = xe;
      py_d = ye;
      pz_d = p;
      if (mode_in == VECTOR) begin
         pz_d = '0;
         if (xe[OUT_W-1]) begin
            px_d = -xe;
            py_d = -ye;
            pz_d = HALF;
         end
      end else begin
         case (p[PHASE_W-1 -: 2])
            2'b01:   begin px_d = -ye; py_d = xe;  pz_d = p - QTR;  end
            2'b10:   begin px_d = -xe; py_d = -ye; pz_d = p - HALF; end
            2'b11:   begin px_d = ye;  py_d = -xe; pz_d = p - TQTR; end
            default: begin px_d = xe;  py_d = ye;  pz_d = p;        end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         pv_q  <= 1'b0;
         pm_q  <= ROTATE;
         px_q  <= '0;
         py_q  <= '0;
         pz_q  <= '0;
      end else begin
         acc_q <= acc_d;
         pv_q  <= io.in_valid;
         pm_q  <= mode_in;
         px_q  <= px_d;
         py_q  <= py_d;
         pz_q  <= pz_d;
      end
   end

   logic                    vld_c  [STAGES+1];
   mode_e                   mode_c [STAGES+1];
   logic signed [OUT_W-1:0] x_c    [STAGES+1];
   logic signed [OUT_W-1:0] y_c    [STAGES+1];
   logic [PHASE_W-1:0]      z_c    [STAGES+1];

   assign vld_c[0]  = pv_q;
   assign mode_c[0] = pm_q;
   assign x_c[0]    = px_q;
   assign y_c[0]    = py_q;
   assign z_c[0]    = pz_q;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      cordic_stage #(
         .W     (OUT_W),
         .PW    (PHASE_W),
         .SHIFT (i)
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .vld_i  (vld_c[i]),
         .mode_i (mode_c[i]),
         .x_i    (x_c[i]),
         .y_i    (y_c[i]),
         .z_i    (z_c[i]),
         .vld_o  (vld_c[i+1]),
         .mode_o (mode_c[i+1]),
         .x_o    (x_c[i+1]),
         .y_o    (y_c[i+1]),
         .z_o    (z_c[i+1])
      );
   end

   // Vectoring accumulates the angle with the same sign as atan2(yin, xin)
   assign io.out_valid = vld_c[STAGES];
   assign io.out_mode  = mode_c[STAGES];
   assign io.xout      = x_c[STAGES];
   assign io.yout      = y_c[STAGES];
   assign io.phase_out = z_c[STAGES];
endmodule

// File: tb/tb_cordic_nco_rotator.sv
// Directed bench for cordic_nco_rotator with hand-computed expected vectors.
module tb_cordic_nco_rotator;
   import cordic_pkg::*;

   localparam int  STAGES = 16;
   localparam int  LAT    = STAGES + 1;
   localparam int  KMAG   = (10000 * int'(CORDIC_GAIN) + 16384) >>> 15;
   localparam real PI     = 3.14159265358979;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errs   = 0;
   int   n;
   int   pd;
   logic [31:0] ph;

   cordic_nco_rotator_if #(.IN_W(16), .OUT_W(22), .PHASE_W(32)) io ();

   cordic_nco_rotator #(
      .IN_W    (16),
      .OUT_W   (22),
      .PHASE_W (32),
      .STAGES  (STAGES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, errors=%0d", errs);
      $fatal(1, "watchdog expired");
   end

   task automatic chk_bits(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_near(input string tag, input longint obs, input longint expv, input longint tol);
      bit ok;
      ok = (obs >= expv - tol) && (obs <= expv + tol);
      checks++;
      assert (ok === 1'b1) else begin
         errs++;
         $error("FAIL %s: observed=%0d expected=%0d+/-%0d", tag, obs, expv, tol);
      end
   endtask

   task automatic chk_real(input string tag, input real obs, input real expv, input real tol);
      bit ok;
      ok = (obs >= expv - tol) && (obs <= expv + tol);
      checks++;
      assert (ok === 1'b1) else begin
         errs++;
         $error("FAIL %s: observed=%f expected=%f+/-%f", tag, obs, expv, tol);
      end
   endtask

   task automatic drive(input logic v, input logic m, input int x, input int y,
                        input logic [31:0] step, input logic ld, input logic [31:0] init);
      @(negedge clk);
      io.in_valid   = v;
      io.mode       = m;
      io.xin        = 16'(x);
      io.yin        = 16'(y);
      io.phase_step = step;
      io.phase_load = ld;
      io.phase_init = init;
   endtask

   task automatic idle(input int cnt);
      repeat (cnt) drive(1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic expect_rect(input string tag, input logic m, input longint xe, input longint ye, input longint tol);
      chk_bits({tag, "_vld"}, 64'(io.out_valid), 64'd1);
      chk_bits({tag, "_mode"}, 64'(io.out_mode), 64'(m));
      chk_near({tag, "_x"}, longint'(io.xout), xe, tol);
      chk_near({tag, "_y"}, longint'(io.yout), ye, tol);
   endtask

   task automatic expect_polar(input string tag, input real deg_e);
      real xr, yr, a, d;
      xr = real'(longint'(io.xout));
      yr = real'(longint'(io.yout));
      a  = $atan2(yr, xr) * 180.0 / PI;
      if (a < 0.0) a = a + 360.0;
      d  = a - deg_e;
      if (d > 180.0) d = d - 360.0;
      else if (d < -180.0) d = d + 360.0;
      chk_bits({tag, "_vld"}, 64'(io.out_valid), 64'd1);
      chk_real({tag, "_mag"}, $sqrt(xr * xr + yr * yr), real'(KMAG), 4.0);
      chk_real({tag, "_ang"}, deg_e + d, deg_e, 0.05);
   endtask

   initial begin
      rst_n         = 1'b0;
      io.in_valid   = 1'b0;
      io.mode       = 1'b0;
      io.xin        = '0;
      io.yin        = '0;
      io.phase_step = '0;
      io.phase_load = 1'b0;
      io.phase_init = '0;
      repeat (3) @(negedge clk);
      chk_bits("rst_out_valid", 64'(io.out_valid), 64'd0);
      chk_bits("rst_out_mode",  64'(io.out_mode),  64'd0);
      chk_bits("rst_xout",      64'(io.xout),      64'd0);
      chk_bits("rst_yout",      64'(io.yout),      64'd0);
      chk_bits("rst_phase_out", 64'(io.phase_out), 64'd0);
      rst_n = 1'b1;

      // Continuous valid from reset, zero phase
      drive(1'b1, 1'b0, 10000, 0, 32'h0, 1'b0, 32'h0);
      n = 0;
      while (io.out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk_bits("t1_latency", 64'(n), 64'(LAT));
      chk_near("t1_x", longint'(io.xout), KMAG, 4);
      chk_near("t1_y", longint'(io.yout), 0, 4);

      // Quarter-turn steps through all four pre-rotation quadrants
      drive(1'b1, 1'b0, 10000, 0, 32'h4000_0000, 1'b1, 32'h0);
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 10000, 0, 32'h4000_0000, 1'b0, 32'h0);
      idle(LAT - 3);
      expect_rect("t2_0deg", 1'b0, KMAG, 0, 4);
      idle(1);
      expect_rect("t2_90deg", 1'b0, 0, KMAG, 4);
      idle(1);
      expect_rect("t2_180deg", 1'b0, -KMAG, 0, 4);
      idle(1);
      expect_rect("t2_270deg", 1'b0, 0, -KMAG, 4);

      // 75 degree steps; sample 5 wraps the accumulator past 2^32
      for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, 10000, 0, 32'h3555_5555, (k == 0), 32'h0);
      idle(LAT - 5);
      ph = 32'h0;
      for (int k = 0; k < 6; k++) begin
         expect_polar($sformatf("t3_s%0d", k), real'(ph) / 4294967296.0 * 360.0);
         ph = ph + 32'h3555_5555;
         idle(1);
      end

      // Rotate and vector samples interleaved
      drive(1'b1, 1'b0, 10000, 0, 32'h0, 1'b1, 32'h0);
      drive(1'b1, 1'b1, -10000, 0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 10000, 0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 0, 10000, 32'h0, 1'b0, 32'h0);
      idle(LAT - 3);
      expect_rect("t4_rot0", 1'b0, KMAG, 0, 4);
      idle(1);
      expect_rect("t4_vec180", 1'b1, KMAG, 0, 4);
      pd = int'(io.phase_out - 32'h8000_0000);
      chk_near("t4_vec180_phase_err", longint'(pd), 0, 1 << 18);
      idle(1);
      expect_rect("t4_rot1", 1'b0, KMAG, 0, 4);
      idle(1);
      expect_rect("t4_vec90", 1'b1, KMAG, 0, 4);
      pd = int'(io.phase_out - 32'h4000_0000);
      chk_near("t4_vec90_phase_err", longint'(pd), 0, 1 << 18);

      // Gapped valid with a phase load on the first sample
      drive(1'b1, 1'b0, 10000, 0, 32'h1000_0000, 1'b1, 32'h2000_0000);
      idle(2);
      drive(1'b1, 1'b0, 10000, 0, 32'h1000_0000, 1'b0, 32'h0);
      idle(LAT - 3);
      expect_rect("t5_s0_45deg", 1'b0, 11645, 11645, 5);
      idle(1);
      chk_bits("t5_gap1_vld", 64'(io.out_valid), 64'd0);
      idle(1);
      chk_bits("t5_gap2_vld", 64'(io.out_valid), 64'd0);
      idle(1);
      expect_rect("t5_s1_67deg", 1'b0, 6302, 15214, 5);

      // Reset in mid-stream with a moving accumulator
      drive(1'b1, 1'b0, 10000, 0, 32'h0800_0000, 1'b1, 32'h0);
      drive(1'b1, 1'b0, 10000, 0, 32'h0800_0000, 1'b0, 32'h0);
      repeat (LAT + 1) @(negedge clk);
      chk_bits("t6_vld_before_rst", 64'(io.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_bits("t6_vld_in_rst", 64'(io.out_valid), 64'd0);
      chk_bits("t6_xout_in_rst", 64'(io.xout), 64'd0);
      chk_bits("t6_phase_in_rst", 64'(io.phase_out), 64'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      io.in_valid   = 1'b0;
      io.phase_load = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         idle(1);
         if (io.out_valid !== 1'b0) n++;
      end
      chk_bits("t6_quiet_after_rst", 64'(n), 64'd0);
      drive(1'b1, 1'b0, 10000, 0, 32'h1000_0000, 1'b0, 32'h0);
      drive(1'b1, 1'b0, -32768, -32768, 32'h1000_0000, 1'b1, 32'h2000_0000);
      n = 1;
      while (io.out_valid !== 1'b1 && n < 200) begin
         idle(1);
         n++;
      end
      chk_bits("t6_latency", 64'(n), 64'(LAT));
      expect_rect("t6_phase0", 1'b0, KMAG, 0, 4);
      idle(1);
      expect_rect("t6_fullscale", 1'b0, 0, -76312, 8);

      idle(2);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
